// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Purpose:
//   Writer side of the instruction memory. Receives a framed byte stream from
//   the host/debug link, assembles little-endian 32-bit words, writes them into
//   the instruction memory write port and finally releases the core from reset
//   once the whole image has arrived with a correct checksum.
//
//   Frame: 4-byte word count L (little-endian), 4*L payload bytes (each word
//   little-endian), one checksum byte = XOR of all payload bytes.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   s_valid      in   host byte valid
//   s_ready      out  loader accepts a byte (combinational from state)
//   s_data       in   host byte
//   load_req     in   single-cycle pulse, restarts a load from DONE or ERR
//   wr           out  memory write enable, 2'b11 word write, 2'b00 idle
//   wr_addr      out  memory byte address
//   wr_data      out  memory write word
//   core_rst_n   out  active-low core reset, high only in DONE
//   busy         out  high while a frame is being received
//   done         out  high once the image is loaded and verified
//   err          out  high after an oversize length or bad checksum
//   words_loaded out  number of words written in the current load
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        load_req,
    output logic [1:0]  wr,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t      state_q,        state_d;
    logic [1:0]  byte_cnt_q,     byte_cnt_d;
    logic [31:0] len_q,          len_d;
    logic [31:0] word_q,         word_d;
    logic [7:0]  csum_q,         csum_d;
    logic [15:0] idx_q,          idx_d;
    logic [1:0]  wr_q,           wr_d;
    logic [31:0] wr_addr_q,      wr_addr_d;
    logic [31:0] wr_data_q,      wr_data_d;
    logic        core_rst_n_q,   core_rst_n_d;
    logic        busy_q,         busy_d;
    logic        done_q,         done_d;
    logic        err_q,          err_d;
    logic [15:0] words_loaded_q, words_loaded_d;

    logic        accept;
    logic [31:0] len_next;
    logic [31:0] word_next;
    logic [31:0] idx_ext;

    // The host may only push bytes while a frame is in progress; there is no
    // other source of backpressure.
    assign s_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign accept  = s_valid && s_ready;

    // Bytes arrive least-significant first, so shifting each new byte in at
    // the top leaves {b3,b2,b1,b0} after four bytes.
    assign len_next  = {s_data, len_q[31:8]};
    assign word_next = {s_data, word_q[31:8]};
    assign idx_ext   = {16'd0, idx_q};

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        len_d          = len_q;
        word_d         = word_q;
        csum_d         = csum_q;
        idx_d          = idx_q;
        wr_d           = 2'b00;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            ST_LEN: begin
                if (accept) begin
                    len_d      = len_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (len_next > MEM_WORDS_L) begin
                            state_d = ST_ERR;
                        end else if (len_next == 32'd0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                            idx_d   = 16'd0;
                        end
                    end
                end
            end

            ST_DATA: begin
                if (accept) begin
                    word_d     = word_next;
                    csum_d     = csum_q ^ s_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Address arithmetic deliberately wraps at 2^32.
                        wr_d           = 2'b11;
                        wr_addr_d      = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        wr_data_d      = word_next;
                        words_loaded_d = words_loaded_q + 16'd1;
                        idx_d          = idx_q + 16'd1;
                        // The last write is registered in this same cycle, so
                        // it is on the bus before the checksum byte can land.
                        if (idx_ext + 32'd1 == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end

            ST_CSUM: begin
                if (accept) begin
                    state_d = (s_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end

            ST_DONE, ST_ERR: begin
                if (load_req) begin
                    state_d        = ST_LEN;
                    byte_cnt_d     = 2'd0;
                    len_d          = 32'd0;
                    csum_d         = 8'd0;
                    idx_d          = 16'd0;
                    words_loaded_d = 16'd0;
                end
            end

            default: begin
                state_d = ST_LEN;
            end
        endcase

        // Status outputs are derived from the next state so that they change
        // together with the state register.
        core_rst_n_d = (state_d == ST_DONE);
        busy_d       = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        done_d       = (state_d == ST_DONE);
        err_d        = (state_d == ST_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_LEN;
            byte_cnt_q     <= 2'd0;
            len_q          <= 32'd0;
            word_q         <= 32'd0;
            csum_q         <= 8'd0;
            idx_q          <= 16'd0;
            wr_q           <= 2'b00;
            wr_addr_q      <= 32'd0;
            wr_data_q      <= 32'd0;
            core_rst_n_q   <= 1'b0;
            busy_q         <= 1'b1;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            words_loaded_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            len_q          <= len_d;
            word_q         <= word_d;
            csum_q         <= csum_d;
            idx_q          <= idx_d;
            wr_q           <= wr_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            core_rst_n_q   <= core_rst_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign wr           = wr_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign core_rst_n   = core_rst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = words_loaded_q;

endmodule
